// File: rtl/load_store_unit_if.sv
// Request/acknowledge data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: issues one bus access per load/store, stalls the
// core until it completes. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read_en,
  input  logic               MemWrite,
  input  logic [1:0]         Store,
  input  logic [2:0]         Load,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               stall,
  output logic [31:0]        rdata,
  output logic               bus_err,
  output logic               misalign_err,
  load_store_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, next_state;
  logic [31:0]      addr_q, wdata_q;
  logic [1:0]       store_q;
  logic [2:0]       load_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             start, misaligned, timeout;
  logic [1:0]       off;
  logic [3:0]       strb;
  logic [31:0]      lane_wdata, load_fmt;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign start   = mem_read_en | MemWrite;
  assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign off     = addr_q[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  // The store size decides alignment whenever MemWrite is set, since the write wins.
  always_comb begin
    misaligned = 1'b0;
    if (MemWrite) begin
      case (Store)
        2'b01:   misaligned = addr[0];
        2'b10:   misaligned = 1'b0;
        default: misaligned = |addr[1:0];
      endcase
    end else begin
      case (Load)
        3'b000, 3'b011: misaligned = 1'b0;
        3'b001, 3'b100: misaligned = addr[0];
        default:        misaligned = |addr[1:0];
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    bus.mem_req = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall      = 1'b1;
          next_state = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall       = 1'b1;
        bus.mem_req = 1'b1;
        if (bus.mem_ack || timeout) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    strb       = 4'b1111;
    lane_wdata = wdata_q;
    case (store_q)
      2'b01: begin
        strb       = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        strb       = 4'b0001 << off;
        lane_wdata = {4{wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  assign bus.mem_we    = (state == BUSY) & we_q;
  assign bus.mem_wstrb = bus.mem_we ? strb : 4'b0000;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = lane_wdata;

  assign rd_byte = bus.mem_rdata[{off, 3'b000} +: 8];
  assign rd_half = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (load_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b011:  load_fmt = {24'b0, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {16'b0, rd_half};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  // Error flags are set only on the edge that enters DONE, so they pulse for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      store_q      <= '0;
      load_q       <= '0;
      we_q         <= 1'b0;
      cnt          <= '0;
      rdata        <= '0;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= next_state;
      bus_err      <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            store_q <= Store;
            load_q  <= Load;
            we_q    <= MemWrite;
            if (misaligned) begin
              misalign_err <= 1'b1;
              rdata        <= '0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (bus.mem_ack) begin
            if (!we_q) rdata <= load_fmt;
          end else if (timeout) begin
            rdata   <= '0;
            bus_err <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
